// File: rtl/wptr_full_ctrl_pkg.sv
// rtl/wptr_full_ctrl_pkg.sv - shared async FIFO constants and Gray/binary helpers
package async_fifo_pkg;

   localparam int DEFAULT_ADDR_W      = 8;
   localparam int DEFAULT_SYNC_STAGES = 2;

   // Only the low 'width' bits are meaningful; upper bits are forced to zero
   // so that the prefix-XOR below does not pull garbage down.
   function automatic logic [31:0] width_mask(input int unsigned width);
      logic [31:0] mask;
      if (width >= 32)
         mask = '1;
      else
         mask = (32'd1 << width) - 32'd1;
      return mask;
   endfunction

   function automatic logic [31:0] gray_to_bin(input logic [31:0] gray, input int unsigned width);
      logic [31:0] bin;
      bin = gray & width_mask(width);
      for (int s = 1; s < 32; s = s * 2)
         bin = bin ^ (bin >> s);
      return bin;
   endfunction

   function automatic logic [31:0] bin_to_gray(input logic [31:0] bin, input int unsigned width);
      logic [31:0] b;
      b = bin & width_mask(width);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/wptr_full_ctrl_if.sv
// rtl/wptr_full_ctrl_if.sv - write-side client/controller signal bundle
interface wptr_full_ctrl_if #(
   parameter int ADDR_W = async_fifo_pkg::DEFAULT_ADDR_W
);
   logic              w_inc;
   logic [ADDR_W:0]   rptr_gray;
   logic [ADDR_W:0]   w_afull_thresh;
   logic              w_ovf_clr;
   logic [ADDR_W-1:0] waddr;
   logic [ADDR_W:0]   wptr;
   logic              wfull;
   logic              w_afull;
   logic [ADDR_W:0]   w_count;
   logic              w_overflow;

   modport master (
      output w_inc, rptr_gray, w_afull_thresh, w_ovf_clr,
      input  waddr, wptr, wfull, w_afull, w_count, w_overflow
   );

   modport slave (
      input  w_inc, rptr_gray, w_afull_thresh, w_ovf_clr,
      output waddr, wptr, wfull, w_afull, w_count, w_overflow
   );
endinterface

// File: rtl/wptr_full_ctrl_gray_sync.sv
// rtl/wptr_full_ctrl_gray_sync.sv - multi-flop synchroniser for a Gray-coded pointer
module gray_sync #(
   parameter int WIDTH  = async_fifo_pkg::DEFAULT_ADDR_W + 1,
   parameter int STAGES = async_fifo_pkg::DEFAULT_SYNC_STAGES
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH-1:0] sync_q [STAGES];

   // Shift the foreign-domain value through STAGES flops; only one bit of a
   // Gray pointer moves at a time, so a metastable first stage resolves to
   // either the old or the new pointer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < STAGES; i++)
            sync_q[i] <= '0;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++)
            sync_q[i] <= sync_q[i-1];
      end
   end

   assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/wptr_full_ctrl.sv
// rtl/wptr_full_ctrl.sv - write-domain pointer, full/almost-full, count and overflow controller
module wptr_full_ctrl
   import async_fifo_pkg::*;
#(
   parameter int ADDR_W      = DEFAULT_ADDR_W,
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic             w_clk,
   input  logic             w_rst,
   wptr_full_ctrl_if.slave  bus
);
   localparam int              PW    = ADDR_W + 1;
   localparam logic [PW-1:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};

   logic [PW-1:0] wbin_q,  wbin_d;
   logic [PW-1:0] wgray_q, wgray_d;
   logic          wfull_q, wfull_d;
   logic          afull_q, afull_d;
   logic [PW-1:0] count_q, count_d;
   logic          ovf_q,   ovf_d;

   logic [PW-1:0] rptr_sync;
   logic [PW-1:0] rbin;
   logic          accept;

   gray_sync #(
      .WIDTH  (PW),
      .STAGES (SYNC_STAGES)
   ) u_rptr_sync (
      .clk_i (w_clk),
      .rst_i (w_rst),
      .d_i   (bus.rptr_gray),
      .q_o   (rptr_sync)
   );

   assign rbin = PW'(gray_to_bin(32'(rptr_sync), PW));

   // Next pointer and flag values; full/count are judged against the
   // post-write pointer so the flags line up with the registered pointer.
   always_comb begin
      accept  = bus.w_inc & ~wfull_q;
      wbin_d  = wbin_q + PW'(accept);
      wgray_d = PW'(bin_to_gray(32'(wbin_d), PW));
      // Full when the pointers match except for the two MSBs of the Gray code,
      // i.e. the writer is exactly one lap ahead of the synchronised reader.
      wfull_d = (wgray_d == {~rptr_sync[ADDR_W:ADDR_W-1], rptr_sync[ADDR_W-2:0]});
      count_d = wbin_d - rbin;
      afull_d = (bus.w_afull_thresh != '0) && (count_d >= bus.w_afull_thresh);
      ovf_d   = ovf_q;
      if (bus.w_inc && wfull_q)
         ovf_d = 1'b1;
      else if (bus.w_ovf_clr)
         ovf_d = 1'b0;
   end

   // State registers; cleared asynchronously so a reset mid-burst takes
   // effect before the next edge.
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         wbin_q  <= '0;
         wgray_q <= '0;
         wfull_q <= 1'b0;
         afull_q <= 1'b0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         wgray_q <= wgray_d;
         wfull_q <= wfull_d;
         afull_q <= afull_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.waddr      = wbin_q[ADDR_W-1:0];
   assign bus.wptr       = wgray_q;
   assign bus.wfull      = wfull_q;
   assign bus.w_afull    = afull_q;
   assign bus.w_count    = count_q;
   assign bus.w_overflow = ovf_q;

   a_no_accept_when_full: assert property (
      @(posedge w_clk) disable iff (w_rst) !(accept && wfull_q));

   a_gray_one_bit: assert property (
      @(posedge w_clk) disable iff (w_rst) $countones(wgray_q ^ $past(wgray_q)) <= 1);

   a_count_bounded: assert property (
      @(posedge w_clk) disable iff (w_rst) count_q <= DEPTH);

   a_clean_after_reset: assert property (
      @(posedge w_clk) $fell(w_rst) |->
         (wbin_q == '0 && wgray_q == '0 && !wfull_q && !afull_q && count_q == '0 && !ovf_q));
endmodule
